// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode encoding, datapath widths and the arbiter FSM state type
// shared by the ALU arbiter and its users.
package alu_pkg;

    localparam int DW  = 32;
    localparam int OPW = 5;

    localparam logic [OPW-1:0] ALUOP_NOP   = 5'd0;
    localparam logic [OPW-1:0] ALUOP_ADD   = 5'd1;
    localparam logic [OPW-1:0] ALUOP_SUB   = 5'd2;
    localparam logic [OPW-1:0] ALUOP_AND   = 5'd3;
    localparam logic [OPW-1:0] ALUOP_OR    = 5'd4;
    localparam logic [OPW-1:0] ALUOP_XOR   = 5'd5;
    localparam logic [OPW-1:0] ALUOP_SLL   = 5'd6;
    localparam logic [OPW-1:0] ALUOP_SRL   = 5'd7;
    localparam logic [OPW-1:0] ALUOP_SLT   = 5'd8;
    localparam logic [OPW-1:0] ALUOP_SLTU  = 5'd9;
    localparam logic [OPW-1:0] ALUOP_LUI   = 5'd10;
    localparam logic [OPW-1:0] ALUOP_AUIPC = 5'd11;
    localparam logic [OPW-1:0] ALUOP_MUL   = 5'd12;
    localparam logic [OPW-1:0] ALUOP_MULH  = 5'd13;
    localparam logic [OPW-1:0] ALUOP_DIV   = 5'd14;
    localparam logic [OPW-1:0] ALUOP_DIVU  = 5'd15;
    localparam logic [OPW-1:0] ALUOP_REM   = 5'd16;
    localparam logic [OPW-1:0] ALUOP_SRA   = 5'd17;
    localparam logic [OPW-1:0] ALUOP_MAX   = ALUOP_SRA;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} arb_state_t;

    // nop and anything past the last defined code are flagged as errors
    function automatic logic op_illegal(input logic [OPW-1:0] op);
        return (op == ALUOP_NOP) || (op > ALUOP_MAX);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU-side and response signals of the shared-ALU arbiter;
// slave = arbiter side, master = requesters plus ALU side.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [DW-1:0]  req0_a;
    logic [DW-1:0]  req1_a;
    logic [DW-1:0]  req0_b;
    logic [DW-1:0]  req1_b;
    logic [OPW-1:0] req0_op;
    logic [OPW-1:0] req1_op;
    logic [DW-1:0]  req0_pc;
    logic [DW-1:0]  req1_pc;

    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [DW-1:0]  alu_pc;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_c;
    logic [7:0]     alu_zero;

    logic           rsp_valid;
    logic           rsp_id;
    logic [DW-1:0]  rsp_data;
    logic           rsp_zero;
    logic           rsp_err;
    logic [1:0]     rsp_ready;

    modport slave (
        input  req_valid, req0_a, req1_a, req0_b, req1_b, req0_op, req1_op, req0_pc, req1_pc,
        output req_ready,
        output alu_a, alu_b, alu_pc, alu_op,
        input  alu_c, alu_zero,
        output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req0_a, req1_a, req0_b, req1_b, req0_op, req1_op, req0_pc, req1_pc,
        input  req_ready,
        input  alu_a, alu_b, alu_pc, alu_op,
        output alu_c, alu_zero,
        input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err,
        output rsp_ready
    );

endinterface

// File: rtl/alu_rr_pick.sv
// alu_rr_pick: combinational 2-way grant picker, round-robin on last_grant by default,
// fixed priority to requester 0 when ALU_ARB_PRIO_EN is defined; zero latency, no state.
module alu_rr_pick (
    input  logic [1:0] req_valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

`ifdef ALU_ARB_PRIO_EN
    logic last_grant_unused;
    assign last_grant_unused = last_grant_i;
`endif

    always_comb begin
        grant_o = 2'b00;
        case (req_valid_i)
            2'b01: grant_o = 2'b01;
            2'b10: grant_o = 2'b10;
            2'b11: begin
`ifdef ALU_ARB_PRIO_EN
                grant_o = 2'b01;
`else
                // under contention the requester not served last time wins
                grant_o = last_grant_i ? 2'b01 : 2'b10;
`endif
            end
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two requesters (ALU_ARB_PRIO_EN = fixed priority).
// Accept -> rsp_valid in 3 cycles; response held until rsp_ready[rsp_id], req_ready low while busy.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    alu_arbiter_if.slave bus
);

    arb_state_t     state_q, state_d;
    logic           owner_q, owner_d;
    logic           last_grant_q, last_grant_d;
    logic           err_pend_q, err_pend_d;
    logic [DW-1:0]  alu_a_q, alu_a_d;
    logic [DW-1:0]  alu_b_q, alu_b_d;
    logic [DW-1:0]  alu_pc_q, alu_pc_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic [DW-1:0]  rsp_data_q, rsp_data_d;
    logic           rsp_zero_q, rsp_zero_d;
    logic           rsp_err_q, rsp_err_d;

    logic [1:0]     grant;
    logic           accept;
    logic           rsp_hs;
    logic [DW-1:0]  sel_a, sel_b, sel_pc;
    logic [OPW-1:0] sel_op;
    logic           zero_hi_unused;

    alu_rr_pick u_pick (
        .req_valid_i  (bus.req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign sel_a  = grant[1] ? bus.req1_a  : bus.req0_a;
    assign sel_b  = grant[1] ? bus.req1_b  : bus.req0_b;
    assign sel_pc = grant[1] ? bus.req1_pc : bus.req0_pc;
    assign sel_op = grant[1] ? bus.req1_op : bus.req0_op;

    assign accept = (state_q == IDLE) && (grant != 2'b00);
    assign rsp_hs = (state_q == RESP) && bus.rsp_ready[rsp_id_q];

    assign zero_hi_unused = ^bus.alu_zero[7:1];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        err_pend_d   = err_pend_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_pc_d     = alu_pc_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d    = grant[1];
                    alu_a_d    = sel_a;
                    alu_b_d    = sel_b;
                    alu_pc_d   = sel_pc;
                    alu_op_d   = sel_op;
                    // opcode leaves the ALU inputs after issue, so the error flag is kept aside
                    err_pend_d = op_illegal(sel_op);
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                alu_a_d  = '0;
                alu_b_d  = '0;
                alu_pc_d = '0;
                alu_op_d = '0;
                state_d  = CAPT;
            end
            CAPT: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = owner_q;
                rsp_data_d  = bus.alu_c;
                rsp_zero_d  = bus.alu_zero[0];
                rsp_err_d   = err_pend_q;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    rsp_valid_d  = 1'b0;
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            err_pend_q   <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_pc_q     <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            err_pend_q   <= err_pend_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_pc_q     <= alu_pc_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE) ? (grant & bus.req_valid) : 2'b00;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_pc    = alu_pc_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
